vend_ctrl_param: RTL
====================

// Module: vend_ctrl_param
// PURPOSE
//  Parametrised vending controller: multi-denomination coin intake, credit accumulation,
//  NUM_ITEMS-product selection with per-item price and stock check, cancel/refund,
//  inactivity timeout and serial change payout (largest coin first).
//  Sits between coin-acceptor/keypad front end and dispenser/coin-hopper drivers.
// PARAMETERS
//  CREDIT_W   8                       width of credit, prices, coin values
//  NUM_ITEMS  4                       number of products (>=2)
//  PRICES     {8'd12,8'd7,8'd5,8'd3}  packed NUM_ITEMS*CREDIT_W; item i = PRICES[i*CREDIT_W +: CREDIT_W]
//  COIN_VALS  {8'd10,8'd5,8'd2,8'd1}  packed 4*CREDIT_W; coin k value; COIN_VALS[k] strictly increasing in k, coin 0 == 1
//  MAX_CREDIT 20                      credit ceiling; must be < 2**CREDIT_W
//  TIMEOUT    16                      idle cycles in COLLECT before auto-refund (>=1)
// PORTS
//  clk          in   1         clock, rising edge
//  arstn        in   1         synchronous active-low reset
//  coin_valid   in   1         coin inserted this cycle
//  coin_sel     in   2         denomination index of inserted coin
//  sel_valid    in   1         product selection strobe
//  sel_item     in   IW        IW=$clog2(NUM_ITEMS); product index
//  cancel       in   1         refund request
//  stock_empty  in   NUM_ITEMS bit i high = item i sold out
//  vend         out  1         1-cycle dispense pulse
//  vend_item    out  IW        item dispensed, valid with vend
//  change_vld   out  1         1-cycle pulse per returned coin
//  change_sel   out  2         denomination of returned coin
//  coin_reject  out  1         1-cycle pulse: inserted coin returned unaccepted
//  sel_err      out  1         1-cycle pulse: selection refused
//  busy         out  1         high in VEND/CHANGE
//  credit       out  CREDIT_W  current credit
// BEHAVIOUR
//  - All outputs registered; response to an input appears the cycle after it is sampled.
//  - Reset (arstn=0 at clk edge): state IDLE, credit=0, idle counter=0, all outputs 0.
//    Mid-operation reset discards credit and any pending change; no refund.
//  - States: IDLE, COLLECT, VEND, CHANGE.
//  - Priority per cycle in IDLE/COLLECT: cancel > sel_valid > coin_valid.
//  - Coin: accepted if credit+value <= MAX_CREDIT and no cancel/accepted sel this cycle;
//    credit += value, IDLE->COLLECT. Otherwise coin_reject, credit unchanged.
//    Any coin in VEND/CHANGE -> coin_reject. Sum computed CREDIT_W+1 wide (no wrap).
//  - Selection (COLLECT only): sel_item >= NUM_ITEMS, stock_empty[sel_item]=1, or
//    credit < price -> sel_err, state/credit unchanged (a same-cycle coin is then still
//    evaluated). Else -> VEND; credit -= price.
//    sel_valid in IDLE -> sel_err.
//  - VEND (1 cycle): vend=1, vend_item=selected item. Next: CHANGE if credit>0, else IDLE.
//  - cancel in COLLECT -> CHANGE (full refund). cancel in IDLE/VEND/CHANGE ignored.
//  - CHANGE: each cycle change_vld=1, change_sel = largest k with COIN_VALS[k] <= credit;
//    credit -= value. Credit 0 after payout -> IDLE, change_vld low that cycle.
//  - Timeout: counter clears on entry to COLLECT and on any accepted coin or refused sel;
//    increments other COLLECT cycles; at TIMEOUT -> CHANGE (auto-refund).
//  - busy = (state==VEND || state==CHANGE). Credit never exceeds MAX_CREDIT.
// TESTING (defaults)
//  1 coin 1, coin 2, sel 0 -> credit 1,3; vend=1 item0; credit 0; IDLE; no change_vld
//  2 coin 10, sel 2 -> vend item2; change_vld sel=1 (2), then sel=0 (1); credit 0; IDLE
//  3 coin 10 x2, coin 1 -> credit 20; coin_reject; credit stays 20; cancel -> two pulses sel=3
//  4 credit 5, sel 3 -> sel_err, credit 5; stock_empty[1]=1, sel 1 -> sel_err;
//    coin 2, idle 16 cycles -> auto-refund: change_vld sel=2 (5), then sel=1 (2)
//  5 credit 3, same cycle sel 0 + coin 1 -> vend item0, coin_reject;
//    coin during CHANGE -> coin_reject
//  6 arstn=0 during CHANGE -> next cycle all outputs 0, credit 0, IDLE; no further change_vld

Source files
------------

// File: rtl/vend_ctrl_param_if.sv
// Vending controller front-end / driver bundle.
// master: coin acceptor, keypad and dispenser side; slave: controller.
interface vend_ctrl_param_if #(
  parameter int CREDIT_W  = 8,
  parameter int NUM_ITEMS = 4
);
  localparam int IW = $clog2(NUM_ITEMS);

  logic                 coin_valid;
  logic [1:0]           coin_sel;
  logic                 sel_valid;
  logic [IW-1:0]        sel_item;
  logic                 cancel;
  logic [NUM_ITEMS-1:0] stock_empty;
  logic                 vend;
  logic [IW-1:0]        vend_item;
  logic                 change_vld;
  logic [1:0]           change_sel;
  logic                 coin_reject;
  logic                 sel_err;
  logic                 busy;
  logic [CREDIT_W-1:0]  credit;

  modport master (
    output coin_valid, coin_sel, sel_valid,
    output sel_item, cancel, stock_empty,
    input  vend, vend_item, change_vld,
    input  change_sel, coin_reject, sel_err,
    input  busy, credit
  );

  modport slave (
    input  coin_valid, coin_sel, sel_valid,
    input  sel_item, cancel, stock_empty,
    output vend, vend_item, change_vld,
    output change_sel, coin_reject, sel_err,
    output busy, credit
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// Vending controller: coin intake, selection with price/stock
// check, cancel/timeout refund and largest-first change payout.
module vend_ctrl_param #(
  parameter int CREDIT_W  = 8,
  parameter int NUM_ITEMS = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES =
    {8'd12, 8'd7, 8'd5, 8'd3},
  parameter logic [4*CREDIT_W-1:0] COIN_VALS =
    {8'd10, 8'd5, 8'd2, 8'd1},
  parameter int MAX_CREDIT = 20,
  parameter int TIMEOUT    = 16
) (
  input logic clk,
  input logic arstn,
  vend_ctrl_param_if.slave io
);
  localparam int IW = $clog2(NUM_ITEMS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = CREDIT_W + 1;

  typedef enum logic [1:0] {
    IDLE, COLLECT, VEND, CHANGE
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                vend_q, vend_d;
  logic [IW-1:0]       item_q, item_d;
  logic                chg_q, chg_d;
  logic [1:0]          csel_q, csel_d;
  logic                rej_q, rej_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] coin_val, chg_val, price;
  logic [1:0]          chg_sel;
  logic                in_range, sold_out, sel_ok;
  logic [SW-1:0]       sum;
  logic                coin_fit, coin_take, tmr_clr;

  // Lookups; the change coin is the largest value not above credit.
  always_comb begin
    coin_val = '0;
    chg_val  = '0;
    chg_sel  = '0;
    price    = '0;
    in_range = 1'b0;
    sold_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (io.coin_sel == 2'(k))
        coin_val = COIN_VALS[k*CREDIT_W +: CREDIT_W];
      if (COIN_VALS[k*CREDIT_W +: CREDIT_W] <= credit_q) begin
        chg_sel = 2'(k);
        chg_val = COIN_VALS[k*CREDIT_W +: CREDIT_W];
      end
    end
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (io.sel_item == IW'(i)) begin
        in_range = 1'b1;
        price    = PRICES[i*CREDIT_W +: CREDIT_W];
        sold_out = io.stock_empty[i];
      end
    end
  end

  assign sel_ok   = in_range && !sold_out && (credit_q >= price);
  assign sum      = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fit = sum <= SW'(MAX_CREDIT);

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    tmr_d     = tmr_q;
    vend_d    = 1'b0;
    item_d    = '0;
    chg_d     = 1'b0;
    csel_d    = '0;
    rej_d     = 1'b0;
    err_d     = 1'b0;
    coin_take = 1'b0;
    tmr_clr   = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (io.cancel) begin
          if (state_q == COLLECT) state_d = CHANGE;
        end else if (io.sel_valid && state_q == COLLECT
                     && sel_ok) begin
          state_d  = VEND;
          credit_d = credit_q - price;
          vend_d   = 1'b1;
          item_d   = io.sel_item;
        end else begin
          if (io.sel_valid) begin
            err_d   = 1'b1;
            tmr_clr = 1'b1;
          end
          if (io.coin_valid && coin_fit) begin
            credit_d  = sum[CREDIT_W-1:0];
            state_d   = COLLECT;
            coin_take = 1'b1;
            tmr_clr   = 1'b1;
          end
        end
        rej_d = io.coin_valid && !coin_take;
        // Idle counter only runs while staying in COLLECT.
        if (state_q == IDLE || state_d != COLLECT) begin
          tmr_d = '0;
        end else if (tmr_clr) begin
          tmr_d = '0;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          tmr_d   = '0;
          state_d = CHANGE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      VEND: begin
        rej_d   = io.coin_valid;
        state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_d = io.coin_valid;
        if (credit_q != '0) begin
          chg_d    = 1'b1;
          csel_d   = chg_sel;
          credit_d = credit_q - chg_val;
          if (credit_d == '0) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == VEND) || (state_d == CHANGE);

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q  <= IDLE;
      credit_q <= '0;
      tmr_q    <= '0;
      vend_q   <= 1'b0;
      item_q   <= '0;
      chg_q    <= 1'b0;
      csel_q   <= '0;
      rej_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmr_q    <= tmr_d;
      vend_q   <= vend_d;
      item_q   <= item_d;
      chg_q    <= chg_d;
      csel_q   <= csel_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign io.vend        = vend_q;
  assign io.vend_item   = item_q;
  assign io.change_vld  = chg_q;
  assign io.change_sel  = csel_q;
  assign io.coin_reject = rej_q;
  assign io.sel_err     = err_q;
  assign io.busy        = busy_q;
  assign io.credit      = credit_q;
endmodule
